// File: rtl/sqrd_pivot_sched_pkg.sv
// Shared constants, FSM encoding and vector packing helpers for the
// sorted-QR pivot scheduler and its running-min sub-block.
`ifndef COLNORM_WL
`define COLNORM_WL 16
`endif

package sqrd_pivot_sched_pkg;

   localparam int unsigned NCOL = 8;
   localparam int unsigned IW   = 3;
   localparam int unsigned NW   = `COLNORM_WL;

   typedef logic [IW-1:0] idx_t;
   typedef logic [NW-1:0] norm_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEARCH,
      S_ISSUE,
      S_WAIT_UPD,
      S_DONE
   } state_e;

   function automatic norm_t norm_at(input logic [NCOL*NW-1:0] v, input int unsigned i);
      return v[i*NW +: NW];
   endfunction

   function automatic logic [NCOL*IW-1:0] pack_order(input idx_t o [NCOL]);
      logic [NCOL*IW-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < NCOL; k++) begin
         r[k*IW +: IW] = o[k];
      end
      return r;
   endfunction

endpackage

// File: rtl/sqrd_pivot_sched_if.sv
// Exchange-command / norm-update link between the pivot scheduler (master)
// and the column-exchange datapath (slave).
interface sqrd_pivot_sched_if;
   import sqrd_pivot_sched_pkg::*;

   logic                 step_valid_o;
   logic                 step_ready_i;
   idx_t                 step_tarcol_o;
   idx_t                 step_mincol_o;
   logic                 upd_valid_i;
   logic [NCOL*NW-1:0]   upd_norm_i;

   modport master (
      output step_valid_o, step_tarcol_o, step_mincol_o,
      input  step_ready_i, upd_valid_i, upd_norm_i
   );

   modport slave (
      input  step_valid_o, step_tarcol_o, step_mincol_o,
      output step_ready_i, upd_valid_i, upd_norm_i
   );
endinterface

// File: rtl/sqrd_pivot_sched_argmin_seq.sv
// Sequential running-min comparator: seed loads the first candidate, each
// step replaces it only on strict less-than, so ties keep the lowest index.
module argmin_seq
   import sqrd_pivot_sched_pkg::*;
#(
   parameter int unsigned W   = NW,
   parameter int unsigned IDW = IW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           seed_i,
   input  logic           step_i,
   input  logic [W-1:0]   val_i,
   input  logic [IDW-1:0] idx_i,
   output logic [IDW-1:0] min_idx_o
);

   logic [W-1:0]   min_val_q;
   logic [IDW-1:0] min_idx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         min_val_q <= '0;
         min_idx_q <= '0;
      end else if (seed_i) begin
         min_val_q <= val_i;
         min_idx_q <= idx_i;
      end else if (step_i && (val_i < min_val_q)) begin
         min_val_q <= val_i;
         min_idx_q <= idx_i;
      end
   end

   assign min_idx_o = min_idx_q;

endmodule

// File: rtl/sqrd_pivot_sched.sv
// Column-pivot scheduler: eight min-norm search / exchange / down-date steps
// producing the sorted-QR detection order.
module sqrd_pivot_sched
   import sqrd_pivot_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [NCOL*NW-1:0]    norm_init_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [NCOL*IW-1:0]    order_o,
   sqrd_pivot_sched_if.master    step_if
);

   state_e state_q;
   idx_t   tar_q;
   idx_t   cnt_q;
   norm_t  norm_q  [NCOL];
   idx_t   order_q [NCOL];
   logic   busy_q;
   logic   done_q;
   logic   valid_q;
   idx_t   min_idx;
   logic   search;

   assign search = (state_q == S_SEARCH);

   // The scan always starts at the target column, so the seed cycle is cnt==tar.
   argmin_seq #(.W(NW), .IDW(IW)) u_argmin (
      .clk       (clk),
      .rst       (rst),
      .seed_i    (search && (cnt_q == tar_q)),
      .step_i    (search),
      .val_i     (norm_q[cnt_q]),
      .idx_i     (cnt_q),
      .min_idx_o (min_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tar_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         for (int unsigned k = 0; k < NCOL; k++) begin
            norm_q[k]  <= '0;
            order_q[k] <= idx_t'(k);
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  for (int unsigned k = 0; k < NCOL; k++) begin
                     norm_q[k]  <= norm_at(norm_init_i, k);
                     order_q[k] <= idx_t'(k);
                  end
                  tar_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (cnt_q == idx_t'(NCOL-1)) begin
                  valid_q <= 1'b1;
                  state_q <= S_ISSUE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_ISSUE: begin
               if (step_if.step_ready_i) begin
                  valid_q         <= 1'b0;
                  norm_q[tar_q]   <= norm_q[min_idx];
                  norm_q[min_idx] <= norm_q[tar_q];
                  order_q[tar_q]   <= order_q[min_idx];
                  order_q[min_idx] <= order_q[tar_q];
                  if (tar_q == idx_t'(NCOL-1)) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_WAIT_UPD;
                  end
               end
            end
            S_WAIT_UPD: begin
               if (step_if.upd_valid_i) begin
                  for (int unsigned k = 0; k < NCOL; k++) begin
                     if (idx_t'(k) > tar_q) begin
                        norm_q[k] <= norm_at(step_if.upd_norm_i, k);
                     end
                  end
                  tar_q   <= tar_q + 1'b1;
                  cnt_q   <= tar_q + 1'b1;
                  state_q <= S_SEARCH;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o                = busy_q;
   assign done_o                = done_q;
   assign order_o               = pack_order(order_q);
   assign step_if.step_valid_o  = valid_q;
   assign step_if.step_tarcol_o = tar_q;
   assign step_if.step_mincol_o = min_idx;

endmodule

// File: tb/tb_sqrd_pivot_sched.sv
// Scoreboard bench for sqrd_pivot_sched: directed runs push expected commands
// and completions; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_sqrd_pivot_sched;
   import sqrd_pivot_sched_pkg::*;

   typedef struct { int tar; int mincol; int cyc; } cmd_t;
   typedef struct { logic [NCOL*IW-1:0] order; int cyc; } done_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start_i = 1'b0;
   logic [NCOL*NW-1:0]   norm_init_i = '0;
   logic                 busy_o;
   logic                 done_o;
   logic [NCOL*IW-1:0]   order_o;
   logic                 rdy = 1'b1;
   logic                 dp_upd = 1'b0;
   logic                 junk_upd = 1'b0;
   logic [NCOL*NW-1:0]   upd_norm = '0;

   sqrd_pivot_sched_if bus();

   assign bus.step_ready_i = rdy;
   assign bus.upd_valid_i  = dp_upd | junk_upd;
   assign bus.upd_norm_i   = upd_norm;

   sqrd_pivot_sched dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .norm_init_i (norm_init_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .order_o     (order_o),
      .step_if     (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   cmd_t  exp_cmd[$];
   done_t exp_done[$];
   int rdy_from = 100000, rdy_len = 0;
   int junk_from = 100000, junk_len = 0;
   int unsigned dp_norm[NCOL];
   bit zero_col6 = 1'b0;

   int unsigned base_n[NCOL]  = '{50, 30, 90, 30, 70, 10, 80, 20};
   int unsigned equal_n[NCOL] = '{100, 100, 100, 100, 100, 100, 100, 100};
   int mins_a[NCOL]   = '{5, 7, 3, 7, 5, 5, 6, 7};
   int ord_a[NCOL]    = '{5, 7, 3, 1, 0, 4, 6, 2};
   int hs_a[NCOL]     = '{9, 18, 26, 33, 39, 44, 48, 51};
   int hs_stall[NCOL] = '{9, 18, 31, 38, 44, 49, 53, 56};
   int ident[NCOL]    = '{0, 1, 2, 3, 4, 5, 6, 7};
   int mins_z[NCOL]   = '{5, 6, 7, 3, 6, 5, 6, 7};
   int ord_z[NCOL]    = '{5, 6, 7, 3, 1, 0, 4, 2};
   int ord_mid[NCOL]  = '{5, 7, 3, 2, 4, 0, 6, 1};

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic logic [NCOL*IW-1:0] pk_order(input int o[NCOL]);
      logic [NCOL*IW-1:0] r;
      r = '0;
      for (int k = 0; k < NCOL; k++) r[k*IW +: IW] = IW'(o[k]);
      return r;
   endfunction

   // Cycle 0 is the edge that samples an accepted start_i.
   always @(posedge clk) cyc <= (start_i && !busy_o) ? 0 : cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      rdy      = !((cyc + 1) >= rdy_from && (cyc + 1) < rdy_from + rdy_len);
      junk_upd = ((cyc + 1) >= junk_from && (cyc + 1) < junk_from + junk_len);
   end

   // Datapath stand-in: applies each exchange to its own norm copy and
   // returns it in the first WAIT_UPD cycle.
   initial forever begin
      int t, m;
      int unsigned tmp;
      @(negedge clk);
      if (!rst && bus.step_valid_o && bus.step_ready_i && bus.step_tarcol_o != 3'd7) begin
         t = int'(bus.step_tarcol_o);
         m = int'(bus.step_mincol_o);
         tmp = dp_norm[t]; dp_norm[t] = dp_norm[m]; dp_norm[m] = tmp;
         if (zero_col6 && t == 0) begin
            dp_norm[6] = 0;
            dp_norm[0] = 0;
         end
         @(posedge clk);
         #1;
         for (int k = 0; k < NCOL; k++) upd_norm[k*NW +: NW] = NW'(dp_norm[k]);
         dp_upd = 1'b1;
         @(posedge clk);
         #1;
         dp_upd   = 1'b0;
         upd_norm = '0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (bus.step_valid_o) begin
            if (exp_cmd.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_cmd: tar %0d min %0d, none expected", bus.step_tarcol_o, bus.step_mincol_o);
            end else begin
               check("cmd_tarcol", 64'(bus.step_tarcol_o), 64'(exp_cmd[0].tar));
               check("cmd_mincol", 64'(bus.step_mincol_o), 64'(exp_cmd[0].mincol));
               if (bus.step_ready_i) begin
                  check("hs_cycle", 64'(cyc + 1), 64'(exp_cmd[0].cyc));
                  void'(exp_cmd.pop_front());
               end
            end
         end
         if (done_o) begin
            if (exp_done.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: order %h, none expected", order_o);
            end else begin
               check("done_order", 64'(order_o), 64'(exp_done[0].order));
               check("done_cycle", 64'(cyc + 1), 64'(exp_done[0].cyc));
               check("done_busy", 64'(busy_o), 64'd1);
               void'(exp_done.pop_front());
            end
         end
      end
   end

   task automatic push_run(input int mins[NCOL], input int hs[NCOL], input int ord[NCOL], input int dcyc);
      done_t d;
      for (int t = 0; t < NCOL; t++) exp_cmd.push_back('{t, mins[t], hs[t]});
      d.order = pk_order(ord);
      d.cyc   = dcyc;
      exp_done.push_back(d);
   endtask

   task automatic start_run(input int unsigned n[NCOL]);
      for (int k = 0; k < NCOL; k++) begin
         norm_init_i[k*NW +: NW] = NW'(n[k]);
         dp_norm[k] = n[k];
      end
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic sync_to(input int n);
      int k = 0;
      while (cyc != n - 1 && k < 500) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while ((exp_cmd.size() != 0 || exp_done.size() != 0) && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({name, "_drained"}, 64'(exp_cmd.size() + exp_done.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy",   64'(busy_o), 64'd0);
      check("rst_done",   64'(done_o), 64'd0);
      check("rst_valid",  64'(bus.step_valid_o), 64'd0);
      check("rst_tarcol", 64'(bus.step_tarcol_o), 64'd0);
      check("rst_mincol", 64'(bus.step_mincol_o), 64'd0);
      check("rst_order",  64'(order_o), 64'(pk_order(ident)));

      push_run(mins_a, hs_a, ord_a, 52);
      start_run(base_n);
      wait_drain("basic");

      push_run(ident, hs_a, ident, 52);
      start_run(equal_n);
      wait_drain("equal");

      rdy_from = 26;
      rdy_len  = 5;
      push_run(mins_a, hs_stall, ord_a, 57);
      start_run(base_n);
      wait_drain("stall");
      rdy_len = 0;

      zero_col6 = 1'b1;
      push_run(mins_z, hs_a, ord_z, 52);
      start_run(base_n);
      wait_drain("upd_zero");
      zero_col6 = 1'b0;

      junk_from = 12;
      junk_len  = 3;
      push_run(mins_a, hs_a, ord_a, 52);
      start_run(base_n);
      sync_to(5);
      norm_init_i = '0;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      sync_to(20);
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      wait_drain("noise");
      junk_len = 0;

      rdy_from = 33;
      rdy_len  = 1000;
      push_run(mins_a, hs_a, ord_a, 52);
      start_run(base_n);
      sync_to(34);
      check("mid_order",  64'(order_o), 64'(pk_order(ord_mid)));
      check("mid_valid",  64'(bus.step_valid_o), 64'd1);
      rst = 1'b1;
      exp_cmd.delete();
      exp_done.delete();
      @(posedge clk);
      #1;
      check("rst3_busy",  64'(busy_o), 64'd0);
      check("rst3_valid", 64'(bus.step_valid_o), 64'd0);
      check("rst3_order", 64'(order_o), 64'(pk_order(ident)));
      rst = 1'b0;
      rdy_len = 0;
      @(posedge clk);
      #1;
      push_run(mins_a, hs_a, ord_a, 52);
      start_run(base_n);
      wait_drain("after_rst");
      check("final_busy", 64'(busy_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
